// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined execute ALU.
//   ALU_CTRL_W  : opcode width
//   alu_op_e    : every opcode the unit knows, including the Zba shift-adds
//   alu_res_t   : result (up to 64 bits) plus illegal flag
//   is_legal    : opcode legality for a given XLEN and build
//   alu_compute : combinational ALU evaluated at 64 bits, masked to xlen
// Build option: define ALU_ZBA_EN to enable the Zba opcodes 10000..10110.
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD       = 5'b00000,
    OP_SUB       = 5'b00001,
    OP_AND       = 5'b00010,
    OP_OR        = 5'b00011,
    OP_XOR       = 5'b00100,
    OP_SLL       = 5'b00101,
    OP_SRL       = 5'b00110,
    OP_SRA       = 5'b00111,
    OP_ADDW      = 5'b01000,
    OP_SUBW      = 5'b01001,
    OP_SLLW      = 5'b01010,
    OP_SRLW      = 5'b01011,
    OP_SRAW      = 5'b01100,
    OP_SLT       = 5'b01101,
    OP_SLTU      = 5'b01110,
    OP_SH1ADD    = 5'b10000,
    OP_SH2ADD    = 5'b10001,
    OP_SH3ADD    = 5'b10010,
    OP_ADD_UW    = 5'b10011,
    OP_SH1ADD_UW = 5'b10100,
    OP_SH2ADD_UW = 5'b10101,
    OP_SH3ADD_UW = 5'b10110
  } alu_op_e;

  typedef struct packed {
    logic [63:0] result;
    logic        illegal;
  } alu_res_t;

  function automatic logic is_legal(input logic [ALU_CTRL_W-1:0] op, input int unsigned xlen);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU:    ok = 1'b1;
      OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW: ok = (xlen == 64);
`ifdef ALU_ZBA_EN
      OP_SH1ADD, OP_SH2ADD, OP_SH3ADD:             ok = 1'b1;
      OP_ADD_UW, OP_SH1ADD_UW, OP_SH2ADD_UW,
      OP_SH3ADD_UW:                                ok = (xlen == 64);
`endif
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Operands arrive zero-extended to 64 bits. For xlen=32 the signed views
  // are rebuilt from bit 31 so compares and SRA see the 32-bit sign, and the
  // result is masked back to 32 bits at the end.
  function automatic alu_res_t alu_compute(input logic [63:0] a, input logic [63:0] b,
                                           input logic [ALU_CTRL_W-1:0] op,
                                           input int unsigned xlen);
    alu_res_t    r;
    logic [63:0] a_s, b_s, a_u;
    logic [5:0]  sh;
    logic [31:0] w;
    r = '0;
    w = '0;
    if (xlen == 32) begin
      a_s = {{32{a[31]}}, a[31:0]};
      b_s = {{32{b[31]}}, b[31:0]};
      a_u = {32'b0, a[31:0]};
      sh  = {1'b0, b[4:0]};
    end else begin
      a_s = a;
      b_s = b;
      a_u = a;
      sh  = b[5:0];
    end
    if (!is_legal(op, xlen)) begin
      r.illegal = 1'b1;
    end else begin
      case (op)
        OP_ADD:  r.result = a + b;
        OP_SUB:  r.result = a - b;
        OP_AND:  r.result = a & b;
        OP_OR:   r.result = a | b;
        OP_XOR:  r.result = a ^ b;
        OP_SLL:  r.result = a << sh;
        OP_SRL:  r.result = a_u >> sh;
        OP_SRA:  r.result = $signed(a_s) >>> sh;
        OP_SLT:  r.result = {63'b0, $signed(a_s) < $signed(b_s)};
        OP_SLTU: r.result = {63'b0, a_s < b_s};
        OP_ADDW: begin w = a[31:0] + b[31:0];                 r.result = {{32{w[31]}}, w}; end
        OP_SUBW: begin w = a[31:0] - b[31:0];                 r.result = {{32{w[31]}}, w}; end
        OP_SLLW: begin w = a[31:0] << b[4:0];                 r.result = {{32{w[31]}}, w}; end
        OP_SRLW: begin w = a[31:0] >> b[4:0];                 r.result = {{32{w[31]}}, w}; end
        OP_SRAW: begin w = $signed(a[31:0]) >>> b[4:0];       r.result = {{32{w[31]}}, w}; end
`ifdef ALU_ZBA_EN
        OP_SH1ADD:    r.result = b + (a << 1);
        OP_SH2ADD:    r.result = b + (a << 2);
        OP_SH3ADD:    r.result = b + (a << 3);
        OP_ADD_UW:    r.result = b + {32'b0, a[31:0]};
        OP_SH1ADD_UW: r.result = b + ({32'b0, a[31:0]} << 1);
        OP_SH2ADD_UW: r.result = b + ({32'b0, a[31:0]} << 2);
        OP_SH3ADD_UW: r.result = b + ({32'b0, a[31:0]} << 3);
`endif
        default: r.illegal = 1'b1;
      endcase
      if (xlen == 32) r.result[63:32] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: one elastic register slice (valid + payload).
//   clk, reset : clock, synchronous active-high reset
//   flush_i    : drop the held entry on the next edge
//   valid_i    : upstream entry present
//   data_i     : upstream payload
//   ready_i    : downstream accepts this cycle
//   valid_o    : this slice holds an entry
//   data_o     : held payload
// The slice loads whenever it is empty or its entry leaves this cycle; the
// upstream ready (!valid_o || ready_i) is formed by the parent.
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!valid_q || ready_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      // NOTE: the payload register is reset as well, because the outputs
      // must read all-zero after reset, not just invalid.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: elastic pipelined integer ALU for the EX stage.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : kill all in-flight ops; input not taken that cycle
//   in_valid/in_ready, in_ctrl, in_a, in_b, in_tag : op handshake and operands
//   out_valid/out_ready, out_result, out_zero, out_illegal, out_tag : result
// Parameters: XLEN (32/64), PIPE_STAGES (1..4), TAG_W.
// Build option: ALU_ZBA_EN enables the Zba shift-add opcodes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]       in_a,
  input  logic [XLEN-1:0]       in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic                  out_zero,
  output logic                  out_illegal,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int PW = TAG_W + 2 + XLEN;

  logic [63:0]     a64, b64;
  alu_res_t        res;
  logic [XLEN-1:0] res_x;

  assign a64   = 64'(in_a);
  assign b64   = 64'(in_b);
  assign res   = alu_compute(a64, b64, in_ctrl, XLEN);
  assign res_x = res.result[XLEN-1:0];

  // vld[0] is the producer's valid; vld[s+1] is the valid of slice s.
  logic [PIPE_STAGES:0]         vld;
  logic [PIPE_STAGES:0][PW-1:0] dat;

  assign vld[0] = in_valid;
  assign dat[0] = {in_tag, res.illegal, (res_x == '0), res_x};

  // A slice can accept when any slice downstream of it has a hole or the
  // consumer takes the output. Derived from the valid flops directly so
  // the ready path is a flat AND tree rather than a rippling chain.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic dn_rdy;
    if (s == PIPE_STAGES - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = out_ready || !(&vld[PIPE_STAGES:s+2]);
    end

    alu_pipe_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .valid_i (vld[s]),
      .data_i  (dat[s]),
      .ready_i (dn_rdy),
      .valid_o (vld[s+1]),
      .data_o  (dat[s+1])
    );
  end

  assign in_ready  = (out_ready || !(&vld[PIPE_STAGES:1])) && !flush;
  assign out_valid = vld[PIPE_STAGES];
  assign {out_tag, out_illegal, out_zero, out_result} = dat[PIPE_STAGES];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe. A 64-bit, 2-stage instance is
// driven through a scoreboard (expected values pushed on acceptance, popped
// when the output handshakes); a 32-bit, 1-stage instance is checked directly.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int PS = 2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal;
  logic [4:0]  in_ctrl, in_tag, out_tag;
  logic [63:0] in_a, in_b, out_result;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_zero32, out_illegal32;
  logic [4:0]  in_ctrl32, in_tag32, out_tag32;
  logic [31:0] in_a32, in_b32, out_result32;

  alu_pipe #(.XLEN(64), .PIPE_STAGES(PS), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  alu_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_ctrl(in_ctrl32),
    .in_a(in_a32), .in_b(in_b32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
    .out_zero(out_zero32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    logic [4:0]  tag;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Output monitor: stability under backpressure and scoreboard compare.
  initial begin : monitor
    bit          hold_q;
    logic [63:0] h_res;
    logic        h_zero, h_ill;
    logic [4:0]  h_tag;
    exp_t        e;
    hold_q = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_q) begin
        check("hold_valid",  out_valid,   1'b1);
        check("hold_result", out_result,  h_res);
        check("hold_zero",   out_zero,    h_zero);
        check("hold_ill",    out_illegal, h_ill);
        check("hold_tag",    out_tag,     h_tag);
      end
      hold_q = out_valid && !out_ready && !reset && !flush;
      h_res  = out_result;
      h_zero = out_zero;
      h_ill  = out_illegal;
      h_tag  = out_tag;
      if (out_valid && out_ready && !reset) begin
        if (sb.size() == 0) begin
          n_checks++;
          $error("FAIL sb_unexpected: observed tag %0d expected no output", out_tag);
        end else begin
          e = sb.pop_front();
          check("sb_result", out_result,  e.res);
          check("sb_zero",   out_zero,    e.zero);
          check("sb_ill",    out_illegal, e.ill);
          check("sb_tag",    out_tag,     e.tag);
          if (e.chk_lat) check("latency", 64'(cyc - e.acc), 64'(PS));
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input logic [63:0] exp_res, input logic exp_ill,
                      input bit chk_lat);
    exp_t e;
    bit   taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp_res; e.zero = (exp_res == 64'd0); e.ill = exp_ill;
        e.tag = tag; e.acc = cyc; e.chk_lat = chk_lat;
        sb.push_back(e);
        taken = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!taken) begin
      n_checks++;
      $error("FAIL send_timeout: tag %0d not accepted, expected acceptance", tag);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do32(input string name, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill);
    in_valid32 = 1'b1;
    in_ctrl32  = op;
    in_a32     = a;
    in_b32     = b;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready32, 1'b1);
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    @(negedge clk);
    check({name, "_valid"},  out_valid32,   1'b1);
    check({name, "_result"}, out_result32,  exp_res);
    check({name, "_ill"},    out_illegal32, exp_ill);
    check({name, "_zero"},   out_zero32,    exp_res == 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_ctrl = '0; in_a = '0; in_b = '0; in_tag = '0;
    in_valid32 = 1'b0; in_ctrl32 = '0; in_a32 = '0; in_b32 = '0; in_tag32 = 5'd3;
    out_ready32 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid",    out_valid,   1'b0);
    check("rst_result",   out_result,  64'd0);
    check("rst_zero",     out_zero,    1'b0);
    check("rst_ill",      out_illegal, 1'b0);
    check("rst_tag",      out_tag,     5'd0);
    check("rst_in_ready", in_ready,    1'b1);
    check("rst_valid32",  out_valid32, 1'b0);
    check("rst_ready32",  in_ready32,  1'b1);
    @(posedge clk);
    #1;

    // XLEN=32 instance
    do32("w32_add",   OP_ADD,  32'hFFFF_FFFF, 32'd2,          32'd1,          1'b0);
    do32("w32_sra",   OP_SRA,  32'h8000_0000, 32'h24,         32'hF800_0000,  1'b0);
    do32("w32_sltu",  OP_SLTU, 32'd1,         32'hFFFF_FFFF,  32'd1,          1'b0);
    do32("w32_addw",  OP_ADDW, 32'd5,         32'd6,          32'd0,          1'b1);
    do32("w32_bad",   5'b11111, 32'd5,        32'd6,          32'd0,          1'b1);
    do32("w32_adduw", OP_ADD_UW, 32'd5,       32'd6,          32'd0,          1'b1);
`ifdef ALU_ZBA_EN
    do32("w32_sh1add", OP_SH1ADD, 32'd3,      32'd1,          32'd7,          1'b0);
`else
    do32("w32_sh1add", OP_SH1ADD, 32'd3,      32'd1,          32'd0,          1'b1);
`endif

    // XLEN=64: directed ops through the scoreboard
    send(OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, 64'd0, 1'b0, 1'b1);
    drain();
    send(OP_ADDW, 64'h7FFF_FFFF, 64'd1, 5'd2, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
    send(OP_SRAW, 64'h8000_0000, 64'd4, 5'd3, 64'hFFFF_FFFF_F800_0000, 1'b0, 1'b1);
    send(OP_SUB,  64'd5, 64'd7, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    send(OP_AND,  64'hF0F0, 64'hFF00, 5'd5, 64'hF000, 1'b0, 1'b1);
    send(OP_OR,   64'hF0F0, 64'h0F0F, 5'd6, 64'hFFFF, 1'b0, 1'b1);
    send(OP_XOR,  64'hFFFF, 64'h0F0F, 5'd7, 64'hF0F0, 1'b0, 1'b1);
    send(OP_SLL,  64'd1, 64'd63, 5'd8, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send(OP_SLL,  64'd1, 64'h43, 5'd9, 64'd8, 1'b0, 1'b1);
    send(OP_SRL,  64'h8000_0000_0000_0000, 64'd63, 5'd10, 64'd1, 1'b0, 1'b1);
    send(OP_SRA,  64'h8000_0000_0000_0000, 64'd63, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    send(OP_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd12, 64'd1, 1'b0, 1'b1);
    send(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd13, 64'd0, 1'b0, 1'b1);
    send(OP_SUBW, 64'd0, 64'd1, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    send(OP_SLLW, 64'd1, 64'd31, 5'd15, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
    send(OP_SRLW, 64'hFFFF_FFFF_8000_0000, 64'h3F, 5'd16, 64'd1, 1'b0, 1'b1);
    send(5'b11111, 64'd9, 64'd9, 5'd17, 64'd0, 1'b1, 1'b1);
`ifdef ALU_ZBA_EN
    send(OP_SH2ADD_UW, 64'hDEAD_0000_0000_0010, 64'h1000, 5'd18, 64'h1040, 1'b0, 1'b1);
    send(OP_SH1ADD, 64'd3, 64'd1, 5'd19, 64'd7, 1'b0, 1'b1);
    send(OP_SH3ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd20, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1);
    send(OP_ADD_UW, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd21, 64'h1_0000_0000, 1'b0, 1'b1);
`else
    send(OP_SH2ADD_UW, 64'hDEAD_0000_0000_0010, 64'h1000, 5'd18, 64'd0, 1'b1, 1'b1);
    send(OP_SH1ADD, 64'd3, 64'd1, 5'd19, 64'd0, 1'b1, 1'b1);
`endif
    drain();
    @(posedge clk);
    #1;

    // Stream of 8 ADDs with a 3-cycle output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(OP_ADD, 64'(i * 16), 64'(i), 5'(i), 64'(i * 17), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;

    // Flush with two ops held in the pipe
    out_ready = 1'b0;
    send(OP_ADD, 64'd1, 64'd1, 5'd10, 64'd2, 1'b0, 1'b0);
    send(OP_ADD, 64'd2, 64'd2, 5'd11, 64'd4, 1'b0, 1'b0);
    in_valid = 1'b1; in_ctrl = OP_ADD; in_a = 64'd7; in_b = 64'd7; in_tag = 5'd30;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready_after", in_ready, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(OP_XOR, 64'hAAAA, 64'h5555, 5'd12, 64'hFFFF, 1'b0, 1'b1);
    drain();
    @(posedge clk);
    #1;

    // Reset mid-stream, with the 32-bit instance also holding a result
    out_ready32 = 1'b0;
    in_valid32 = 1'b1; in_ctrl32 = OP_ADD; in_a32 = 32'd5; in_b32 = 32'd6;
    send(OP_ADD, 64'd3, 64'd4, 5'd13, 64'd7, 1'b0, 1'b0);
    in_valid32 = 1'b0;
    send(OP_ADD, 64'd5, 64'd6, 5'd14, 64'd11, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("pre_rst_valid32", out_valid32, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mrst_valid",    out_valid,     1'b0);
    check("mrst_result",   out_result,    64'd0);
    check("mrst_zero",     out_zero,      1'b0);
    check("mrst_ill",      out_illegal,   1'b0);
    check("mrst_tag",      out_tag,       5'd0);
    check("mrst_in_ready", in_ready,      1'b1);
    check("mrst_valid32",  out_valid32,   1'b0);
    check("mrst_result32", out_result32,  32'd0);
    check("mrst_tag32",    out_tag32,     5'd0);
    @(posedge clk);
    #1 out_ready32 = 1'b1;
    send(OP_SUB, 64'd10, 64'd3, 5'd15, 64'd7, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
